// File: rtl/sect_pt_encode.sv
`default_nettype none
// ============================================================================
//  Module   : sect_pt_encode
//  Purpose  : SEC 1 uncompressed point encoder (0x04 || X || Y, or 0x00 for
//             the point at infinity) streaming one octet per handshake.
//  Revision : 1.0  initial release
// ============================================================================
module sect_pt_encode #(
    parameter int M      = 409,
    parameter int NBYTES = (M + 7) / 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         overrun
);

    localparam int c_cw = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int c_cb = NBYTES * 8;
    localparam int c_sw = 2 * c_cb;

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_hdr  = 3'd1;
    localparam logic [2:0] c_xb   = 3'd2;
    localparam logic [2:0] c_yb   = 3'd3;
    localparam logic [2:0] c_inf  = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [c_cw-1:0] r_cnt;
    logic [c_sw-1:0] r_sr;
    logic            w_accept;
    logic            w_cnt_last;
    logic            w_is_inf;
    logic [c_cb-1:0] w_xp;
    logic [c_cb-1:0] w_yp;

    // Both coordinates live in one shift register, X in the upper half, so the
    // current octet is always the top byte and no index arithmetic is needed.
    assign w_xp       = c_cb'(x);
    assign w_yp       = c_cb'(y);
    assign w_is_inf   = (x == '0) && (y == '0);
    assign w_accept   = out_valid & out_ready;
    assign w_cnt_last = (r_cnt == c_cw'(NBYTES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (in_valid) w_next = w_is_inf ? c_inf : c_hdr;
            c_hdr:   if (w_accept) w_next = c_xb;
            c_xb:    if (w_accept && w_cnt_last) w_next = c_yb;
            c_yb:    if (w_accept && w_cnt_last) w_next = c_idle;
            c_inf:   if (w_accept) w_next = c_idle;
            default: w_next = c_idle;
        endcase
        if (clr) w_next = c_idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_idle;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_sr    <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            r_cnt   <= '0;
            overrun <= 1'b0;
        end else begin
            if (in_valid && (r_state != c_idle)) overrun <= 1'b1;
            if ((r_state == c_idle) && in_valid) begin
                r_sr  <= {w_xp, w_yp};
                r_cnt <= '0;
            end else if (w_accept && ((r_state == c_xb) || (r_state == c_yb))) begin
                r_sr  <= {r_sr[c_sw-9:0], 8'h00};
                r_cnt <= w_cnt_last ? '0 : r_cnt + c_cw'(1);
            end
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state != c_idle);
    assign out_last  = (r_state == c_inf) || ((r_state == c_yb) && w_cnt_last);

    always_comb begin
        out_data = 8'h00;
        case (r_state)
            c_hdr:       out_data = 8'h04;
            c_xb, c_yb:  out_data = r_sr[c_sw-1 -: 8];
            default:     out_data = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sect409k1_pt_encode.sv
`default_nettype none
// ============================================================================
//  Module   : sect409k1_pt_encode
//  Purpose  : sect409k1 instance of the generic SEC 1 point encoder.
//  Revision : 1.0  initial release
// ============================================================================
module sect409k1_pt_encode #(
    parameter int M      = 409,
    parameter int NBYTES = 52
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         overrun
);

    sect_pt_encode #(
        .M      (M),
        .NBYTES (NBYTES)
    ) u_enc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

endmodule
`default_nettype wire
